alu_seq_muldiv: RTL and testbench

//  Parametrised, clocked ALU for the datapath: takes Y-register and bus operands on a start strobe, returns a registered
//  2*WIDTH result for the Z register. Single-cycle logic/shift ops, plus iterative signed MUL/DIV over WIDTH cycles.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_muldiv_if.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 84 ++++++++
 rtl/alu_seq_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   OP_*     5-bit opcode encodings presented on the op port.
//   state_e  control FSM states for the top level.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Handshake/operand bundle between the control unit and the sequential ALU.
// Signals:
//   start     1-cycle request strobe, sampled when the ALU is idle
//   op        opcode
//   a_in      operand A (Y register)
//   b_in      operand B (bus)
//   busy      multi-cycle operation in progress
//   done      1-cycle completion pulse
//   result    {hi, lo}, held until the next accepted start
//   zero, carry, overflow, div_zero   status flags, valid with/after done
// Modports: master = control unit side, slave = ALU side.
interface alu_seq_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [4:0]           op;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 zero;
    logic                 carry;
    logic                 overflow;
    logic                 div_zero;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result, zero, carry, overflow, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result, zero, carry, overflow, div_zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide on operand magnitudes.
// One step per cycle while step=1; WIDTH steps complete an operation.
// Ports:
//   clock, clear_n   clock and asynchronous active-low reset
//   load             capture magnitudes and mode, preset counter to WIDTH-1
//   step             perform one iteration
//   is_div           mode for the load: 1 = divide, 0 = multiply
//   a_mag, b_mag     unsigned magnitudes (A = multiplicand / dividend)
//   last             counter has reached 0 (current step is the final one)
//   hi, lo           MUL: product {hi,lo}; DIV: hi = remainder, lo = quotient
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [CNT_W-1:0] count;

    // Multiply: right-shifting product register; the add needs one extra bit
    // which becomes the new top bit after the shift.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   mul_base;
    // Divide: partial remainder shifted left with the next dividend bit.
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    always_comb begin
        add_sum  = {1'b0, acc_hi} + {1'b0, opnd};
        mul_base = acc_lo[0] ? add_sum : {1'b0, acc_hi};
        shifted  = {acc_hi, acc_lo[WIDTH-1]};
        fits     = (shifted >= {1'b0, opnd});
        // When the divisor fits, the true difference is below the divisor,
        // so the low WIDTH bits are exact.
        diff     = shifted[WIDTH-1:0] - opnd;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= is_div ? a_mag : b_mag;
            opnd     <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
            count    <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            if (div_mode) begin
                acc_hi <= fits ? diff : shifted[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], fits};
            end else begin
                acc_hi <= mul_base[WIDTH:1];
                acc_lo <= {mul_base[0], acc_lo[WIDTH-1:1]};
            end
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign last = (count == '0);
    assign hi   = acc_hi;
    assign lo   = acc_lo;

endmodule

// File: rtl/alu_seq_muldiv.sv
// Clocked ALU between the Y register / bus mux and the Z register.
// Single-cycle logic/arith/shift ops complete one edge after the start edge;
// signed MUL/DIV iterate over WIDTH cycles in alu_muldiv_iter and complete
// WIDTH+1 edges after the accepting edge.
// Ports:
//   clock    rising-edge clock
//   clear_n  asynchronous active-low reset (aborts any operation, no done)
//   bus      alu_seq_muldiv_if.slave: start/op/a_in/b_in in,
//            busy/done/result/zero/carry/overflow/div_zero out
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    clear_n,
    alu_seq_muldiv_if.slave         bus
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_e state;
    logic   sign_a;
    logic   neg_res;
    logic   op_div;

    // ---------------- single-cycle datapath ----------------
    logic [SHAMT_W-1:0] shamt;
    logic               add_sub;
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH:0]     add_sum;
    logic               add_ovf;
    logic [WIDTH-1:0]   sc_lo;
    logic [WIDTH-1:0]   sc_hi;
    logic [2*WIDTH-1:0] sc_res;
    logic               sc_carry;
    logic               sc_ovf;
    logic               sc_dz;
    logic               is_multi;

    always_comb begin
        shamt   = bus.b_in[SHAMT_W-1:0];
        // One shared adder: SUB/NEG invert the B side and carry in a 1;
        // NEG computes 0 - A.
        add_sub = (bus.op == OP_SUB) || (bus.op == OP_NEG);
        add_x   = (bus.op == OP_NEG) ? '0 : bus.a_in;
        add_y   = ((bus.op == OP_NEG) ? bus.a_in : bus.b_in) ^ {WIDTH{add_sub}};
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_sub};
        add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                  (add_sum[WIDTH-1] != add_x[WIDTH-1]);

        is_multi = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b_in != '0));

        sc_lo    = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                sc_lo    = add_sum[WIDTH-1:0];
                sc_hi    = {WIDTH{add_sum[WIDTH-1]}};
                sc_carry = add_sum[WIDTH];
                sc_ovf   = add_ovf;
            end
            OP_NEG: begin
                sc_lo  = add_sum[WIDTH-1:0];
                sc_hi  = {WIDTH{add_sum[WIDTH-1]}};
                sc_ovf = add_ovf;
            end
            OP_AND:  sc_lo = bus.a_in & bus.b_in;
            OP_OR:   sc_lo = bus.a_in | bus.b_in;
            OP_NOT:  sc_lo = ~bus.a_in;
            OP_SHR:  sc_lo = bus.a_in >> shamt;
            OP_SHRA: sc_lo = $signed(bus.a_in) >>> shamt;
            OP_SHL:  sc_lo = bus.a_in << shamt;
            // A shift by WIDTH yields 0, so shamt 0 degenerates to A.
            OP_ROR:  sc_lo = (bus.a_in >> shamt) | (bus.a_in << (WIDTH - 32'(shamt)));
            OP_ROL:  sc_lo = (bus.a_in << shamt) | (bus.a_in >> (WIDTH - 32'(shamt)));
            OP_DIV: begin
                // Only reached here with a zero divisor.
                sc_hi = bus.a_in;
                sc_lo = '1;
                sc_dz = 1'b1;
            end
            default: ;
        endcase
        sc_res = {sc_hi, sc_lo};
    end

    // ---------------- iterative MUL/DIV ----------------
    logic             it_load;
    logic             it_step;
    logic             it_last;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Two's-complement magnitude; the most-negative value maps to
    // 2**(WIDTH-1), which is still exact as an unsigned WIDTH-bit number.
    assign a_mag   = bus.a_in[WIDTH-1] ? (~bus.a_in + 1'b1) : bus.a_in;
    assign b_mag   = bus.b_in[WIDTH-1] ? (~bus.b_in + 1'b1) : bus.b_in;
    assign it_load = (state == S_IDLE) && bus.start && is_multi;
    assign it_step = (state == S_ITER);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock   (clock),
        .clear_n (clear_n),
        .load    (it_load),
        .step    (it_step),
        .is_div  (bus.op == OP_DIV),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .last    (it_last),
        .hi      (it_hi),
        .lo      (it_lo)
    );

    // ---------------- sign correction ----------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fix_res;
    logic               div_ovf;

    always_comb begin
        prod    = {it_hi, it_lo};
        mul_res = neg_res ? -prod : prod;
        quot    = neg_res ? -it_lo : it_lo;
        rem     = sign_a  ? -it_hi : it_hi;
        // A positive quotient with the top bit set only arises from
        // most-negative / -1.
        div_ovf = !neg_res && it_lo[WIDTH-1];
        fix_res = op_div ? {rem, quot} : mul_res;
    end

    // ---------------- control FSM and registered outputs ----------------
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state        <= S_IDLE;
            sign_a       <= 1'b0;
            neg_res      <= 1'b0;
            op_div       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.carry    <= 1'b0;
            bus.overflow <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_multi) begin
                            state    <= S_ITER;
                            bus.busy <= 1'b1;
                            sign_a   <= bus.a_in[WIDTH-1];
                            neg_res  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                            op_div   <= (bus.op == OP_DIV);
                        end else begin
                            bus.result   <= sc_res;
                            bus.zero     <= (sc_res == '0);
                            bus.carry    <= sc_carry;
                            bus.overflow <= sc_ovf;
                            bus.div_zero <= sc_dz;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    if (it_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.result   <= fix_res;
                    bus.zero     <= (fix_res == '0);
                    bus.carry    <= 1'b0;
                    bus.overflow <= op_div && div_ovf;
                    bus.div_zero <= 1'b0;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;

    localparam logic [4:0] ADD  = 5'b00011;
    localparam logic [4:0] SUB  = 5'b00100;
    localparam logic [4:0] ANDO = 5'b00101;
    localparam logic [4:0] ORO  = 5'b00110;
    localparam logic [4:0] SHR  = 5'b00111;
    localparam logic [4:0] SHRA = 5'b01000;
    localparam logic [4:0] SHL  = 5'b01001;
    localparam logic [4:0] ROR  = 5'b01010;
    localparam logic [4:0] ROL  = 5'b01011;
    localparam logic [4:0] MUL  = 5'b01111;
    localparam logic [4:0] DIV  = 5'b10000;
    localparam logic [4:0] NEG  = 5'b10001;
    localparam logic [4:0] NOTO = 5'b10010;
    localparam logic [4:0] ILL  = 5'b11111;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        z, c, v, dz;
        int          lat;
        int          bsy;
        int          scyc;
    } exp_t;

    logic clock = 1'b0;
    logic clear_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   busy_run = 0;
    exp_t sb[$];

    alu_seq_muldiv_if #(.WIDTH(32)) bus ();

    alu_seq_muldiv #(.WIDTH(32)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, name, act, exp);
        end
    endtask

    // Drive one start strobe (caller is just after a rising edge) and push
    // the expected response.
    task automatic drive(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic z, input logic c,
                         input logic v, input logic dz, input int lat);
        exp_t e;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        e.tag = tag; e.res = res; e.z = z; e.c = c; e.v = v; e.dz = dz;
        e.lat = lat; e.bsy = (lat > 1) ? lat - 1 : 0; e.scyc = cyc;
        sb.push_back(e);
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
        #1;
        chk(tag, "drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic z, input logic c,
                       input logic v, input logic dz, input int lat);
        @(posedge clock); #1;
        drive(tag, op, a, b, res, z, c, v, dz, lat);
        drain(tag);
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!clear_n) begin
                busy_run = 0;
            end else begin
                if (bus.busy) busy_run++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no pending operation");
                    end else begin
                        e = sb.pop_front();
                        chk(e.tag, "result",   bus.result,   e.res);
                        chk(e.tag, "zero",     64'(bus.zero),     64'(e.z));
                        chk(e.tag, "carry",    64'(bus.carry),    64'(e.c));
                        chk(e.tag, "overflow", 64'(bus.overflow), 64'(e.v));
                        chk(e.tag, "div_zero", 64'(bus.div_zero), 64'(e.dz));
                        chk(e.tag, "latency",  64'(cyc - e.scyc), 64'(e.lat));
                        chk(e.tag, "busy_cycles", 64'(busy_run),  64'(e.bsy));
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t dummy;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #2 clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset", "busy",     64'(bus.busy),     64'd0);
        chk("reset", "done",     64'(bus.done),     64'd0);
        chk("reset", "result",   bus.result,        64'd0);
        chk("reset", "zero",     64'(bus.zero),     64'd0);
        chk("reset", "carry",    64'(bus.carry),    64'd0);
        chk("reset", "overflow", 64'(bus.overflow), 64'd0);
        chk("reset", "div_zero", 64'(bus.div_zero), 64'd0);
        clear_n = 1'b1;

        //   tag           op    a             b             result                 z c v dz lat
        run("add_ovf",    ADD,  32'h7FFFFFFF, 32'h00000001, 64'hFFFFFFFF_80000000, 0,0,1,0, 1);
        run("sub_zero",   SUB,  32'h00000005, 32'h00000005, 64'h00000000_00000000, 1,1,0,0, 1);
        run("sub_borrow", SUB,  32'h00000003, 32'h00000005, 64'hFFFFFFFF_FFFFFFFE, 0,0,0,0, 1);
        run("add_carry",  ADD,  32'hFFFFFFFF, 32'h00000001, 64'h00000000_00000000, 1,1,0,0, 1);
        run("shra",       SHRA, 32'h80000010, 32'h00000004, 64'h00000000_F8000001, 0,0,0,0, 1);
        run("rol",        ROL,  32'h80000001, 32'h00000001, 64'h00000000_00000003, 0,0,0,0, 1);
        run("shl_zero",   SHL,  32'h12345678, 32'h00000020, 64'h00000000_12345678, 0,0,0,0, 1);
        run("shr31",      SHR,  32'h80000000, 32'h0000001F, 64'h00000000_00000001, 0,0,0,0, 1);
        run("ror",        ROR,  32'h00000001, 32'h00000001, 64'h00000000_80000000, 0,0,0,0, 1);
        run("and",        ANDO, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 0,0,0,0, 1);
        run("or",         ORO,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_FFF0FFF0, 0,0,0,0, 1);
        run("not",        NOTO, 32'h00000000, 32'h12345678, 64'h00000000_FFFFFFFF, 0,0,0,0, 1);
        run("neg_min",    NEG,  32'h80000000, 32'h00000000, 64'hFFFFFFFF_80000000, 0,0,1,0, 1);
        run("neg",        NEG,  32'h00000005, 32'h00000000, 64'hFFFFFFFF_FFFFFFFB, 0,0,0,0, 1);
        run("illegal",    ILL,  32'h00000005, 32'h00000003, 64'h00000000_00000000, 1,0,0,0, 1);
        run("mul_neg",    MUL,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 0,0,0,0, 34);
        run("mul_min",    MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 0,0,0,0, 34);
        run("mul_big",    MUL,  32'h00010000, 32'h00010000, 64'h00000001_00000000, 0,0,0,0, 34);
        run("mul_zero",   MUL,  32'h00000000, 32'h00012345, 64'h00000000_00000000, 1,0,0,0, 34);
        run("div_neg",    DIV,  32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 0,0,0,0, 34);
        run("div_negb",   DIV,  32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0,0,0,0, 34);
        run("div_by0",    DIV,  32'h00000009, 32'h00000000, 64'h00000009_FFFFFFFF, 0,0,0,1, 1);
        run("div_ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0,0,1,0, 34);

        // Start while busy is ignored; the original product comes back.
        @(posedge clock); #1;
        drive("mul_busy", MUL, 32'h00000006, 32'h00000007, 64'h00000000_0000002A, 0,0,0,0, 34);
        repeat (9) @(posedge clock);
        #1;
        bus.op = ADD; bus.a_in = 32'h1; bus.b_in = 32'h1; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        drain("mul_busy");

        // Start raised during the done cycle is accepted.
        @(posedge clock); #1;
        drive("mul_b2b", MUL, 32'h00000002, 32'h00000003, 64'h00000000_00000006, 0,0,0,0, 34);
        for (int i = 0; i < 60 && !bus.done; i++) begin
            @(posedge clock); #1;
        end
        chk("mul_b2b", "done_seen", 64'(bus.done), 64'd1);
        drive("add_b2b", ADD, 32'h00000002, 32'h00000003, 64'h00000000_00000005, 0,0,0,0, 1);
        drain("b2b");

        // Reset in the middle of a DIV aborts it without a done pulse.
        @(posedge clock); #1;
        drive("div_abort", DIV, 32'd100, 32'd7, 64'h00000002_0000000E, 0,0,0,0, 34);
        repeat (10) @(posedge clock);
        #1;
        clear_n = 1'b0;
        dummy = sb.pop_back();
        #2;
        chk("abort", "busy",   64'(bus.busy), 64'd0);
        chk("abort", "done",   64'(bus.done), 64'd0);
        chk("abort", "result", bus.result,    64'd0);
        @(posedge clock); #1;
        clear_n = 1'b1;
        repeat (45) @(posedge clock);
        #1;
        chk("abort", "busy_after", 64'(bus.busy), 64'd0);
        run("post_abort", ADD, 32'h00000002, 32'h00000003, 64'h00000000_00000005, 0,0,0,0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
